ili9341_spi_tx: RTL and testbench

//  Write-only 4-wire SPI serializer for the ILI9341 panel (mode 0, MSB first, D/C line).

---
 rtl/ili9341_pkg.sv | 18 +
 rtl/ili9341_spi_tx.sv | 146 ++++++++++++++
 tb/tb_ili9341_spi_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 SPI write path and its upstream sequencer.
package ili9341_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCK_HI = 2'd1,
    ST_SCK_LO = 2'd2,
    ST_GAP    = 2'd3
  } spi_state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam logic [7:0] ILI_CMD_CASET = 8'h2A;
  localparam logic [7:0] ILI_CMD_PASET = 8'h2B;
  localparam logic [7:0] ILI_CMD_RAMWR = 8'h2C;

endpackage

// File: rtl/ili9341_spi_tx.sv
// Write-only mode-0 SPI serializer for the ILI9341: MSB first, D/C line, CS held across bursts.
//
// state  | meaning
// IDLE   | CS high, waiting for a word (ready once the CS gap has elapsed)
// SCK_HI | next edge raises SCLK; on the last bit, latches a back-to-back word
// SCK_LO | next edge drops SCLK and shifts, loads the held word, or ends the burst
// GAP    | first edge raises CS, then counts the minimum CS-high time
module ili9341_spi_tx
  import ili9341_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_dc,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_cs_n,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_dc
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int GAP_W = $clog2(CS_IDLE_CYCLES + 1);

  spi_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  pend_q, pend_d;
  logic                  hold_dc_q, hold_dc_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  dc_q, dc_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      hold_data_q <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      pend_q      <= 1'b0;
      hold_dc_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      dc_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_data_q <= hold_data_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pend_q      <= pend_d;
      hold_dc_q   <= hold_dc_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      dc_q        <= dc_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_data_d = hold_data_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pend_d      = pend_q;
    hold_dc_d   = hold_dc_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    dc_d        = dc_q;
    busy_d      = busy_q;
    o_ready     = ((state_q == ST_IDLE) && (gap_cnt_q == '0)) ||
                  ((state_q == ST_SCK_HI) && (bit_cnt_q == '0));

    case (state_q)
      ST_IDLE: begin
        if (i_valid && o_ready) begin
          shreg_d   = i_data;
          dc_d      = i_dc;
          cs_n_d    = 1'b0;
          bit_cnt_d = BIT_W'(DATA_WIDTH - 1);
          busy_d    = 1'b1;
          state_d   = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        sclk_d  = 1'b1;
        state_d = ST_SCK_LO;
        // Last bit: capture a follow-on word now so the next fall can load it seamlessly.
        if (bit_cnt_q == '0) begin
          pend_d = i_valid;
          if (i_valid) begin
            hold_data_d = i_data;
            hold_dc_d   = i_dc;
          end
        end
      end
      ST_SCK_LO: begin
        sclk_d = 1'b0;
        if (bit_cnt_q != '0) begin
          shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
          state_d   = ST_SCK_HI;
        end else if (pend_q) begin
          shreg_d   = hold_data_q;
          dc_d      = hold_dc_q;
          bit_cnt_d = BIT_W'(DATA_WIDTH - 1);
          pend_d    = 1'b0;
          state_d   = ST_SCK_HI;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!cs_n_q) begin
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          gap_cnt_d = GAP_W'(CS_IDLE_CYCLES);
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy = busy_q;
  assign o_cs_n = cs_n_q;
  assign o_sclk = sclk_q;
  assign o_mosi = shreg_q[DATA_WIDTH-1];
  assign o_dc   = dc_q;

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// Directed bench for ili9341_spi_tx with a pin-level SPI receiver and protocol monitor.
module tb_ili9341_spi_tx;
  import ili9341_pkg::*;

  localparam int DW  = 8;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          dc_in = 1'b0;
  logic          ready, busy, cs_n, sclk, mosi, dc_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [8:0] exp_q[$];
  logic [8:0] stim_q[$];

  ili9341_spi_tx #(.DATA_WIDTH(DW), .CS_IDLE_CYCLES(GAP)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid),
    .i_data (data),
    .i_dc   (dc_in),
    .o_ready(ready),
    .o_busy (busy),
    .o_cs_n (cs_n),
    .o_sclk (sclk),
    .o_mosi (mosi),
    .o_dc   (dc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pin-level receiver: samples each SCLK rise and checks pin stability around it.
  logic       prev_sclk = 1'b0, prev_mosi = 1'b0, prev_dc = 1'b0;
  int         rx_bits = 0, rx_words = 0;
  logic [7:0] rx_byte = '0;
  logic       rx_dc = 1'b0;

  always @(negedge clk) begin
    if (cs_n) chk("sclk_low_while_cs_high", sclk, 0);
    if (rst || cs_n) rx_bits = 0;
    else if (sclk && !prev_sclk) begin
      chk("mosi_stable_at_rise", mosi, prev_mosi);
      chk("dc_stable_at_rise", dc_out, prev_dc);
      if (rx_bits == 0) rx_dc = dc_out;
      rx_byte = {rx_byte[6:0], mosi};
      rx_bits++;
      if (rx_bits == DW) begin
        rx_bits = 0;
        rx_words++;
        chk("rx_word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rx_word", {rx_dc, rx_byte}, exp_q.pop_front());
      end
    end
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_dc   = dc_out;
  end

  task automatic wait_idle();
    for (int i = 0; i < 60 && !(ready && cs_n && !busy); i++) @(negedge clk);
    chk("idle_reached", ready && cs_n && !busy, 1);
  endtask

  task automatic stream(input int n, input bit toggle, input int idle_pct);
    int idx = 0;
    int guard = 0;
    logic [8:0] w;
    while (idx < n && guard < n * 40 + 100) begin
      @(negedge clk);
      guard++;
      if (ready && ($urandom_range(99) >= idle_pct)) begin
        w = stim_q[idx];
        idx++;
        valid = 1'b1;
        {dc_in, data} = w;
        exp_q.push_back(w);
      end else begin
        valid = toggle && !ready;
        if (toggle) begin
          data  = 8'($urandom);
          dc_in = 1'($urandom);
        end
      end
    end
    chk("stream_all_sent", idx, n);
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rises, cs_low, bad_phase, cs_high, rdy0, acc_k;
    logic [7:0] b;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_dc", dc_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // 1: single RAMWR command word
    exp_q.push_back({DC_CMD, ILI_CMD_RAMWR});
    valid = 1'b1; data = ILI_CMD_RAMWR; dc_in = DC_CMD;
    @(negedge clk);
    valid = 1'b0; data = 8'hFF; dc_in = 1'b1;
    chk("t1_cs_low_T0", cs_n, 0);
    chk("t1_busy_T0", busy, 1);
    chk("t1_mosi_T0", mosi, 0);
    rises = 0; b = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (sclk) begin rises++; b = {b[6:0], mosi}; end
    end
    chk("t1_rises", rises, 8);
    chk("t1_bits_at_rises", b, 8'h2C);
    chk("t1_cs_low_T16", cs_n, 0);
    @(negedge clk);
    chk("t1_cs_high_T17", cs_n, 1);
    chk("t1_busy_low_T17", busy, 0);
    chk("t1_ready_low_gap", ready, 0);
    wait_idle();

    // 2: three-word burst with valid held
    exp_q.push_back({DC_CMD, ILI_CMD_CASET});
    exp_q.push_back({DC_DATA, 8'h00});
    exp_q.push_back({DC_DATA, 8'hEF});
    valid = 1'b1; data = ILI_CMD_CASET; dc_in = DC_CMD;
    cs_low = 0; rises = 0; bad_phase = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) begin data = 8'h00; dc_in = DC_DATA; end
      if (k == 15) begin chk("t2_dc_before_T16", dc_out, 0); data = 8'hEF; dc_in = DC_DATA; end
      if (k == 16) begin chk("t2_dc_at_T16", dc_out, 1); chk("t2_mosi_T16", mosi, 0); end
      if (k == 31) valid = 1'b0;
      if (!cs_n) cs_low++;
      if (k < 48 && sclk !== k[0]) bad_phase++;
      if (sclk) rises++;
    end
    chk("t2_cs_low_cycles", cs_low, 49);
    chk("t2_rises", rises, 24);
    chk("t2_sclk_phase_errors", bad_phase, 0);
    wait_idle();

    // 3: valid drops after first word, returns one cycle later
    exp_q.push_back({DC_DATA, 8'h55});
    exp_q.push_back({DC_CMD, 8'hA3});
    valid = 1'b1; data = 8'h55; dc_in = DC_DATA;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    valid = 1'b1; data = 8'hA3; dc_in = DC_CMD;
    cs_high = 0; rdy0 = 0; acc_k = -1;
    for (int k = 16; k < 40; k++) begin
      @(negedge clk);
      if (acc_k >= 0 && k == acc_k + 1) begin
        valid = 1'b0;
        chk("t3_cs_low_restart", cs_n, 0);
        chk("t3_mosi_msb", mosi, 1);
        chk("t3_dc", dc_out, 0);
        chk("t3_sclk_low", sclk, 0);
      end
      if (acc_k < 0 && cs_n) cs_high++;
      if (acc_k < 0 && cs_n && !ready) rdy0++;
      if (valid && ready && acc_k < 0) acc_k = k;
    end
    chk("t3_accept_cycle", acc_k, 19);
    chk("t3_ready_low_cycles", rdy0, GAP);
    chk("t3_cs_high_cycles", cs_high, 3);
    wait_idle();

    // 4: reset mid-word, then a clean word
    exp_q.push_back({DC_CMD, 8'h3C});
    valid = 1'b1; data = 8'h96; dc_in = DC_DATA;
    @(negedge clk);
    valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t4_sclk_high_T7", sclk, 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_cs_n", cs_n, 1);
    chk("t4_rst_sclk", sclk, 0);
    chk("t4_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_ready_after_rst", ready, 1);
    valid = 1'b1; data = 8'h3C; dc_in = DC_CMD;
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    chk("t4_queue_drained", exp_q.size(), 0);

    // 5: inputs toggle while not ready
    stim_q.delete();
    stim_q.push_back({DC_DATA, 8'hB4});
    stim_q.push_back({DC_CMD, 8'h4D});
    stream(2, 1'b1, 0);
    chk("t5_queue_drained", exp_q.size(), 0);

    // 6: random stream with random idle gaps
    stim_q.delete();
    for (int i = 0; i < 200; i++) stim_q.push_back(9'($urandom));
    stream(200, 1'b1, 25);
    chk("t6_queue_drained", exp_q.size(), 0);
    chk("rx_words_total", rx_words, 209);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
